regfile_write_queue: RTL and testbench
======================================

# regfile_write_queue

Write-side front end for the 5-entry, 32-bit register file. It buffers up to DEPTH pending writes from a valid/ready producer (writeback stage or host loader). It drains them one per cycle onto the register file's rw/rd/WriteData port. While writes are pending, it supplies read-after-write bypass data for the rs/rt read addresses. It sits between the datapath writeback and the register file, and is the single owner of the register file write port.

## Interface
- DEPTH, 4: pending-write entries; power of two, 2..16
- NUM_REGS, 5: implemented registers; addresses >= NUM_REGS are out of range
- DATA_W, 32: data width
- ADDR_W, 5: register address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  1  producer has a write
- wr_ready  out  1  queue can accept (count < DEPTH)
- wr_addr  in  ADDR_W  destination register
- wr_data  in  DATA_W  write value
- rf_hold  in  1  suppress draining this cycle
- rf_rw  out  1  register file write enable
- rf_rd  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- rs, rt  in  ADDR_W  current read addresses
- byp_hit_rs, byp_hit_rt  out  1  pending write to rs / rt exists
- byp_data_rs, byp_data_rt  out  DATA_W  youngest pending value for rs / rt
- empty  out  1  no pending writes
- drop_count  out  8  saturating count of out-of-range writes

## Operation
- Circular FIFO: head pointer, tail pointer, count (0..DEPTH), entry array {addr, data}.
- Accept: wr_valid && wr_ready at an edge. In-range addr → entry written at tail, tail++ (wraps mod DEPTH). Out-of-range addr → handshake completes, nothing stored, drop_count++ (saturates at 255).
- Drain: rf_rw = !empty && !rf_hold, combinational. rf_rd/rf_wdata = head entry, and read 0 when empty. On an edge with rf_rw=1, head++ and count--.
- Simultaneous accept and drain: count unchanged. Allowed at any count < DEPTH.
- When full, wr_ready=0 even if a drain occurs this cycle. No pass-through.
- Bypass: search all valid entries, including the head being drained this cycle.
  - byp_hit_x = 1 if any entry addr == x.
  - byp_data_x = data of the youngest match (closest to tail), else 0.
- Writes to register 0 are stored and drained like any other; no special casing.
- Write ordering to the register file is strictly FIFO; no coalescing.
- The "only owner" rule applies: nothing else may drive the register file write port.

## Timing
- Reset values: count=0, head=tail=0, drop_count=0 → empty=1, wr_ready=1, rf_rw=0, rf_rd=0, rf_wdata=0, byp_hit_*=0, byp_data_*=0.
- Reset asserted mid-operation discards all pending writes. No partial drain occurs on the reset edge; rst has priority over accept and drain.
- Latency, idle queue:
  - write accepted at edge N;
  - rf_rw=1 and byp_hit=1 during cycle N..N+1;
  - register file updated at edge N+1;
  - byp_hit drops after N+1 if no other match.
- Bypass outputs are combinational from queue state and rs/rt. There is no comb path from wr_* to any output except wr_ready (and wr_ready depends on count only).
- rf_hold asserted for k cycles delays drain by exactly k cycles; entries and bypass data are retained.

## Structure
- Shared package regfile_pkg:
  - DATA_W, ADDR_W, NUM_REGS constants;
  - wq_entry_t typedef {addr, data}.
- One sub-module, wq_bypass_match: combinational youngest-match search over the entry array given head, count and a lookup address. It returns hit and data, and is instantiated twice (rs, rt).
- Pointer width is clog2(DEPTH); count width is clog2(DEPTH)+1.

## Test plan
- Single write: push addr=3, data=0x55 with rf_hold=0 → rf_rw=1, rf_rd=3, rf_wdata=0x55 for exactly one cycle. Register 3 reads 0x55 afterward. Queue returns to empty=1.
- Fill and drain: rf_hold=1, push addr 1,2,3,4 → wr_ready=0 after the 4th push. Release hold → four consecutive rf_rw cycles in order 1,2,3,4.
- Bypass youngest: hold=1, push (2,0xA) then (2,0xB), with rs=2 → byp_hit_rs=1, byp_data_rs=0xB. After both drain → byp_hit_rs=0.
- Out-of-range: push addr=7 → handshake completes, drop_count=1, no rf_rw. 300 such pushes → drop_count=255.
- Simultaneous push/pop plus wrap: stream 10 back-to-back writes at 1 per cycle with hold=0 → count stays ≤1, and all 10 are drained in order. Pointers wrap past DEPTH without loss.
- Reset mid-op: hold=1, 3 entries queued, assert rst for one cycle → empty=1, rf_rw=0, and no register file write on or after the reset edge.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_pkg: shared register-file widths and write-queue entry type |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 5;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wq_entry_t;

endpackage
`default_nettype wire

// File: rtl/wq_bypass_match.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wq_bypass_match: youngest-match search over the pending writes      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module wq_bypass_match
   import regfile_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  wq_entry_t         entries [DEPTH],
   input  logic [PTR_W-1:0]  head,
   input  logic [PTR_W:0]    count,
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [DATA_W-1:0] data
);

   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest so the last match found is the youngest.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (((PTR_W+1)'(i) < count) && (entries[idx].addr == addr)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_write_queue: buffered register-file write port with bypass  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module regfile_write_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS,
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rf_hold,
   output logic              rf_rw,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   output logic              byp_hit_rs,
   output logic              byp_hit_rt,
   output logic [DATA_W-1:0] byp_data_rs,
   output logic [DATA_W-1:0] byp_data_rt,
   output logic              empty,
   output logic [7:0]        drop_count
);

   localparam int PTR_W = $clog2(DEPTH);

   wq_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;

   logic accept;
   logic in_range;
   logic push;
   logic pop;

   assign empty    = (count == '0);
   assign wr_ready = (count < (PTR_W+1)'(DEPTH));
   assign accept   = wr_valid && wr_ready;
   assign in_range = (wr_addr < ADDR_W'(NUM_REGS));
   assign push     = accept && in_range;

   // Reset overrides drain, so the register file never sees a write on a reset edge.
   assign rf_rw    = !empty && !rf_hold && !rst;
   assign pop      = rf_rw;
   assign rf_rd    = empty ? '0 : mem[head].addr;
   assign rf_wdata = empty ? '0 : mem[head].data;

   always_ff @(posedge clk) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         drop_count <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (accept && !in_range && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

   // Entry storage needs no reset: only slots inside head..count are ever observed.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[tail] <= '{addr: wr_addr, data: wr_data};
      end
   end

   wq_bypass_match #(.DEPTH(DEPTH)) u_match_rs (
      .entries (mem),
      .head    (head),
      .count   (count),
      .addr    (rs),
      .hit     (byp_hit_rs),
      .data    (byp_data_rs)
   );

   wq_bypass_match #(.DEPTH(DEPTH)) u_match_rt (
      .entries (mem),
      .head    (head),
      .count   (count),
      .addr    (rt),
      .hit     (byp_hit_rt),
      .data    (byp_data_rt)
   );

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_write_queue: vector table, corner sequences, random run  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_regfile_write_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rf_hold;
   logic        rf_rw;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        byp_hit_rs;
   logic        byp_hit_rt;
   logic [31:0] byp_data_rs;
   logic [31:0] byp_data_rt;
   logic        empty;
   logic [7:0]  drop_count;

   always #5 clk = ~clk;

   regfile_write_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rf_hold     (rf_hold),
      .rf_rw       (rf_rw),
      .rf_rd       (rf_rd),
      .rf_wdata    (rf_wdata),
      .rs          (rs),
      .rt          (rt),
      .byp_hit_rs  (byp_hit_rs),
      .byp_hit_rt  (byp_hit_rt),
      .byp_data_rs (byp_data_rs),
      .byp_data_rt (byp_data_rt),
      .empty       (empty),
      .drop_count  (drop_count)
   );

   // Register file fed by the DUT's write port.
   logic [31:0] rf_tb [0:7] = '{default: 32'd0};
   int          rf_writes   = 0;
   always @(posedge clk) begin
      if (rf_rw) begin
         rf_tb[rf_rd[2:0]] <= rf_wdata;
         rf_writes         <= rf_writes + 1;
      end
   end

   // Reference model: an ordered list of pending writes.
   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;
   ent_t        mq[$];
   logic [31:0] mrf [0:4];
   int          mdrop;
   logic        m_rw;
   logic        m_ready;
   logic [4:0]  drain_log[$];

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      else
         pass_cnt++;
   endtask

   // Apply inputs, then check every output against the model's view of the queue.
   task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic h, input logic [4:0] s, input logic [4:0] t,
                        input logic r);
      logic        hs, ht;
      logic [31:0] ds, dt;
      wr_valid = v; wr_addr = a; wr_data = d; rf_hold = h; rs = s; rt = t; rst = r;
      #1;
      hs = 0; ht = 0; ds = 0; dt = 0;
      foreach (mq[i]) begin
         if (mq[i].addr == s) begin hs = 1; ds = mq[i].data; end
         if (mq[i].addr == t) begin ht = 1; dt = mq[i].data; end
      end
      m_ready = (mq.size() < DEPTH);
      m_rw    = (mq.size() != 0) && !h && !r;
      chk("empty",    {31'd0, empty},      {31'd0, mq.size() == 0});
      chk("wr_ready", {31'd0, wr_ready},   {31'd0, m_ready});
      chk("rf_rw",    {31'd0, rf_rw},      {31'd0, m_rw});
      chk("rf_rd",    {27'd0, rf_rd},      (mq.size() != 0) ? {27'd0, mq[0].addr} : 32'd0);
      chk("rf_wdata", rf_wdata,            (mq.size() != 0) ? mq[0].data : 32'd0);
      chk("hit_rs",   {31'd0, byp_hit_rs}, {31'd0, hs});
      chk("data_rs",  byp_data_rs,         ds);
      chk("hit_rt",   {31'd0, byp_hit_rt}, {31'd0, ht});
      chk("data_rt",  byp_data_rt,         dt);
      chk("drop",     {24'd0, drop_count}, mdrop);
      if (rf_rw) drain_log.push_back(rf_rd);
   endtask

   task automatic tick();
      if (rst) begin
         mq.delete();
         mdrop = 0;
      end else begin
         if (m_rw) begin
            mrf[mq[0].addr] = mq[0].data;
            void'(mq.pop_front());
         end
         if (wr_valid && m_ready) begin
            if (wr_addr < 5) mq.push_back('{addr: wr_addr, data: wr_data});
            else if (mdrop < 255) mdrop++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic h, input logic [4:0] s);
      drive(v, a, d, h, s, s, 1'b0);
      tick();
   endtask

   typedef struct {
      logic        hold, valid;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [4:0]  rs;
      logic        e_empty, e_ready, e_rw;
      logic [4:0]  e_rd;
      logic [31:0] e_wd;
      logic        e_hit;
      logic [31:0] e_bd;
      logic [7:0]  e_drop;
   } vec_t;
   vec_t vt [11];

   initial begin
      // hold valid addr data rs | empty ready rw rd wdata hit bdata drop
      vt[0]  = '{0, 1, 3, 32'h55, 3,  1, 1, 0, 0, 32'h0,  0, 32'h0,  0};
      vt[1]  = '{0, 0, 0, 32'h0,  3,  0, 1, 1, 3, 32'h55, 1, 32'h55, 0};
      vt[2]  = '{0, 0, 0, 32'h0,  3,  1, 1, 0, 0, 32'h0,  0, 32'h0,  0};
      vt[3]  = '{1, 1, 2, 32'hA,  2,  1, 1, 0, 0, 32'h0,  0, 32'h0,  0};
      vt[4]  = '{1, 1, 2, 32'hB,  2,  0, 1, 0, 2, 32'hA,  1, 32'hA,  0};
      vt[5]  = '{1, 0, 0, 32'h0,  2,  0, 1, 0, 2, 32'hA,  1, 32'hB,  0};
      vt[6]  = '{0, 0, 0, 32'h0,  2,  0, 1, 1, 2, 32'hA,  1, 32'hB,  0};
      vt[7]  = '{0, 0, 0, 32'h0,  2,  0, 1, 1, 2, 32'hB,  1, 32'hB,  0};
      vt[8]  = '{0, 0, 0, 32'h0,  2,  1, 1, 0, 0, 32'h0,  0, 32'h0,  0};
      vt[9]  = '{0, 1, 7, 32'h99, 7,  1, 1, 0, 0, 32'h0,  0, 32'h0,  0};
      vt[10] = '{0, 0, 0, 32'h0,  7,  1, 1, 0, 0, 32'h0,  0, 32'h0,  1};

      mdrop = 0;
      for (int i = 0; i < 5; i++) mrf[i] = 32'd0;
      wr_valid = 0; wr_addr = 0; wr_data = 0; rf_hold = 0; rs = 0; rt = 0; rst = 1;
      repeat (2) @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 1'b1);   // reset state
      tick();

      for (int i = 0; i < 11; i++) begin
         drive(vt[i].valid, vt[i].addr, vt[i].data, vt[i].hold, vt[i].rs, vt[i].rs, 1'b0);
         chk($sformatf("vec%0d_empty", i), {31'd0, empty},      {31'd0, vt[i].e_empty});
         chk($sformatf("vec%0d_ready", i), {31'd0, wr_ready},   {31'd0, vt[i].e_ready});
         chk($sformatf("vec%0d_rw", i),    {31'd0, rf_rw},      {31'd0, vt[i].e_rw});
         chk($sformatf("vec%0d_rd", i),    {27'd0, rf_rd},      {27'd0, vt[i].e_rd});
         chk($sformatf("vec%0d_wdata", i), rf_wdata,            vt[i].e_wd);
         chk($sformatf("vec%0d_hit", i),   {31'd0, byp_hit_rs}, {31'd0, vt[i].e_hit});
         chk($sformatf("vec%0d_bdata", i), byp_data_rs,         vt[i].e_bd);
         chk($sformatf("vec%0d_drop", i),  {24'd0, drop_count}, {24'd0, vt[i].e_drop});
         tick();
      end
      chk("reg3_after_write", rf_tb[3], 32'h55);
      chk("reg2_youngest",    rf_tb[2], 32'hB);

      // Fill under hold, then drain in order.
      for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'h100 + i, 1, 0);
      drive(1, 1, 32'hDEAD, 1, 0, 0, 1'b0);
      chk("full_not_ready", {31'd0, wr_ready}, 32'd0);
      tick();
      drain_log.delete();
      repeat (5) step(0, 0, 0, 0, 0);
      chk("drain_len", drain_log.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < drain_log.size()) chk("drain_order", {27'd0, drain_log[i]}, i + 1);

      // Saturating drop counter.
      repeat (300) step(1, 7, 32'h0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("drop_saturated", {24'd0, drop_count}, 32'd255);

      // Back-to-back stream through a wrapping queue.
      drain_log.delete();
      for (int i = 0; i < 10; i++) begin
         drive(1, 5'(i % 5), 32'h200 + i, 0, 0, 0, 1'b0);
         if (i > 0) chk("stream_rw", {31'd0, rf_rw}, 32'd1);
         tick();
      end
      repeat (2) step(0, 0, 0, 0, 0);
      chk("stream_len", drain_log.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < drain_log.size()) chk("stream_order", {27'd0, drain_log[i]}, i % 5);

      // Reset mid-operation drops pending writes.
      for (int i = 0; i < 3; i++) step(1, 5'(i), 32'h300 + i, 1, 0);
      drive(0, 0, 0, 1, 0, 0, 1'b1);
      tick();
      begin
         int w0;
         w0 = rf_writes;
         drive(0, 0, 0, 0, 1, 1, 1'b0);
         chk("rst_empty", {31'd0, empty}, 32'd1);
         chk("rst_no_rw", {31'd0, rf_rw}, 32'd0);
         tick();
         repeat (3) step(0, 0, 0, 0, 0);
         chk("rst_no_rf_write", rf_writes, w0);
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 800; n++) begin
         drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), ($urandom_range(0, 99) == 0));
         tick();
      end
      repeat (DEPTH + 1) step(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) chk($sformatf("final_reg%0d", i), rf_tb[i], mrf[i]);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
